// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared encodings for the buzzer game datapath
package game_pkg;

  localparam int COUNT_W = 8;

  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_A    = 2'b01;
  localparam logic [1:0] WHO_B    = 2'b10;
  localparam logic [1:0] WHO_BOTH = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARMED  = 2'b01,
    LOCKED = 2'b10,
    DONE   = 2'b11
  } state_e;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - button synchronizer and registered rising-edge press pulse
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic press_q, press_d;

  // Pulse is registered so a pin rise shows up as press three edges later.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    press_d = sync2_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/buzzer_arbiter.sv
// rtl/buzzer_arbiter.sv - arms a round, times the answer window, locks out the second presser
module buzzer_arbiter
  import game_pkg::*;
#(
  parameter int ANSWER_TIME = 200,
  parameter int TICK_DIV    = 100,
  parameter int COUNT_W     = game_pkg::COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               btnA,
  input  logic               btnB,
  input  logic               judge_done,
  output logic [1:0]         who,
  output logic [COUNT_W-1:0] count,
  output logic               armed,
  output logic               lock_pulse,
  output logic               timeout
);

  localparam int PRE_W = $clog2(TICK_DIV);

  logic press_a, press_b;

  btn_edge u_edge_a (.clk(clk), .rst(rst), .raw(btnA), .press(press_a));
  btn_edge u_edge_b (.clk(clk), .rst(rst), .raw(btnB), .press(press_b));

  state_e             state_q, state_d;
  logic [1:0]         who_q, who_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               armed_q, armed_d;
  logic               lock_q, lock_d;
  logic               timeout_q, timeout_d;
  logic               tick;

  assign tick = (pre_q == PRE_W'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    who_d   = who_q;
    count_d = count_q;
    pre_d   = pre_q;
    lock_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ARMED;
          count_d = COUNT_W'(ANSWER_TIME);
          pre_d   = '0;
        end
      end
      ARMED: begin
        // A press outranks a coincident tick, so the frozen count is the pre-tick value.
        if (press_a || press_b) begin
          state_d = LOCKED;
          who_d   = {press_b, press_a};
          lock_d  = 1'b1;
        end else if (tick) begin
          pre_d = '0;
          if (count_q == COUNT_W'(1)) begin
            state_d = DONE;
            count_d = '0;
            who_d   = WHO_NONE;
          end else begin
            count_d = count_q - COUNT_W'(1);
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      LOCKED: begin
        if (judge_done) begin
          state_d = IDLE;
          who_d   = WHO_NONE;
          count_d = '0;
        end
      end
      DONE: begin
        if (judge_done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    armed_d   = (state_d == ARMED);
    timeout_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      who_q     <= WHO_NONE;
      count_q   <= '0;
      pre_q     <= '0;
      armed_q   <= 1'b0;
      lock_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      who_q     <= who_d;
      count_q   <= count_d;
      pre_q     <= pre_d;
      armed_q   <= armed_d;
      lock_q    <= lock_d;
      timeout_q <= timeout_d;
    end
  end

  assign who        = who_q;
  assign count      = count_q;
  assign armed      = armed_q;
  assign lock_pulse = lock_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb/tb_buzzer_arbiter.sv - directed self-checking bench for buzzer_arbiter
module tb_buzzer_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       btnA;
  logic       btnB;
  logic       judge_done;
  logic [1:0] who;
  logic [7:0] count;
  logic       armed;
  logic       lock_pulse;
  logic       timeout;

  int n_checks = 0;
  int n_errors = 0;

  buzzer_arbiter #(.ANSWER_TIME(5), .TICK_DIV(2), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .btnA(btnA), .btnB(btnB),
    .judge_done(judge_done), .who(who), .count(count), .armed(armed),
    .lock_pulse(lock_pulse), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] e_who, input logic [7:0] e_cnt,
                           input logic e_armed, input logic e_lock, input logic e_to);
    check({tag, ".who"},     {30'd0, who},        {30'd0, e_who});
    check({tag, ".count"},   {24'd0, count},      {24'd0, e_cnt});
    check({tag, ".armed"},   {31'd0, armed},      {31'd0, e_armed});
    check({tag, ".lock"},    {31'd0, lock_pulse}, {31'd0, e_lock});
    check({tag, ".timeout"}, {31'd0, timeout},    {31'd0, e_to});
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; btnA = 1'b0; btnB = 1'b0; judge_done = 1'b0;

    // reset with buttons toggling
    for (int i = 0; i < 2; i++) begin
      btnA = ~btnA;
      btnB = btnA;
      tick();
      check_all("reset", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0; btnA = 1'b0; btnB = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("post_reset", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
    end

    // timeout path, with a start pulse mid-round that must not reload
    start = 1'b1; tick(); start = 1'b0;
    check_all("to_arm", 2'b00, 8'd5, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      if (k == 3) start = 1'b1;
      tick();
      start = 1'b0;
      check_all("to_count", 2'b00, 8'(5 - k / 2), 1'b1, 1'b0, 1'b0);
    end
    tick();
    check_all("to_done", 2'b00, 8'd0, 1'b0, 1'b0, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    check_all("to_done_start", 2'b00, 8'd0, 1'b0, 1'b0, 1'b1);
    judge_done = 1'b1; tick(); judge_done = 1'b0;
    check_all("to_idle", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);

    // A wins; pulse lands on a tick edge so count stays at the pre-tick value 2
    start = 1'b1; tick(); start = 1'b0;
    idle_ticks(4);
    check("a_cnt3", {24'd0, count}, 32'd3);
    btnA = 1'b1;
    idle_ticks(3);
    check_all("a_pre", 2'b00, 8'd2, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("a_lock", 2'b01, 8'd2, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("a_hold", 2'b01, 8'd2, 1'b0, 1'b0, 1'b0);
    btnB = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_all("a_late_b", 2'b01, 8'd2, 1'b0, 1'b0, 1'b0);
    end
    btnA = 1'b0; btnB = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check_all("a_start_ign", 2'b01, 8'd2, 1'b0, 1'b0, 1'b0);
    judge_done = 1'b1; tick(); judge_done = 1'b0;
    check_all("a_clear", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
    idle_ticks(4);

    // tie
    start = 1'b1; tick(); start = 1'b0;
    tick();
    btnA = 1'b1; btnB = 1'b1;
    idle_ticks(3);
    check_all("tie_pre", 2'b00, 8'd3, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("tie_lock", 2'b11, 8'd3, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("tie_hold", 2'b11, 8'd3, 1'b0, 1'b0, 1'b0);
    btnA = 1'b0; btnB = 1'b0;
    judge_done = 1'b1; start = 1'b1; tick(); judge_done = 1'b0; start = 1'b0;
    check_all("tie_jd_start", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check_all("tie_stay_idle", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
    idle_ticks(3);

    // button held across start, then release and re-press
    btnA = 1'b1;
    idle_ticks(5);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_all("held", 2'b00, 8'(5 - k / 2), 1'b1, 1'b0, 1'b0);
    end
    btnA = 1'b0; tick();
    btnA = 1'b1;
    idle_ticks(3);
    check_all("repress_pre", 2'b00, 8'd2, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("repress_lock", 2'b01, 8'd2, 1'b0, 1'b1, 1'b0);
    btnA = 1'b0;
    judge_done = 1'b1; tick(); judge_done = 1'b0;
    check_all("repress_clear", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
    idle_ticks(4);

    // press coincides with the 1->0 tick, then reset while locked
    start = 1'b1; tick(); start = 1'b0;
    idle_ticks(6);
    check("last_cnt2", {24'd0, count}, 32'd2);
    btnA = 1'b1;
    idle_ticks(3);
    check_all("last_pre", 2'b00, 8'd1, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("last_lock", 2'b01, 8'd1, 1'b0, 1'b1, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    check_all("last_rst", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);
    btnA = 1'b0;
    tick();
    check_all("last_after", 2'b00, 8'd0, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
